// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state type, sync marker and command codes for the UART command parser
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_PAYLOAD,
    GET_CSUM
  } parser_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_MOTOR = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h02;
  localparam logic [7:0] CMD_PING  = 8'h03;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// rtl/uart_byte_timeout.sv - inter-byte watchdog, pulses expire after TIMEOUT_CLKS-1 idle clocks while enabled
module uart_byte_timeout #(
  parameter int TIMEOUT_CLKS = 7800
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [TW-1:0] count;

  // A restart on the expiry cycle suppresses the pulse: the byte wins.
  assign expire = enable && !restart && (count == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count <= '0;
    end else if (restart || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles SYNC/CMD/LEN/payload/checksum frames from UART bytes into held command registers
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 7800
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_RX_DV,
  input  logic [7:0]           i_RX_Byte,
  output logic                 o_Cmd_Valid,
  output logic [7:0]           o_Cmd,
  output logic [3:0]           o_Len,
  output logic [8*MAX_LEN-1:0] o_Payload,
  output logic                 o_Err_Csum,
  output logic                 o_Err_Len,
  output logic                 o_Err_Timeout,
  output logic [7:0]           o_Frame_Cnt
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);

  parser_state_t state_q, state_d;

  logic [7:0]               cmd_q;
  logic [IDX_W-1:0]         len_q;
  logic [IDX_W-1:0]         idx_q;
  logic [7:0]               sum_q;
  logic [MAX_LEN-1:0][7:0]  buf_q;

  logic timeout;
  logic sync_seen, load_cmd, load_len, store_byte;
  logic frame_ok, csum_bad, len_bad;

  uart_byte_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock(i_Clock),
    .i_Rst_n(i_Rst_n),
    .restart(i_RX_DV),
    .enable (state_q != IDLE),
    .expire (timeout)
  );

  always_comb begin
    state_d    = state_q;
    sync_seen  = 1'b0;
    load_cmd   = 1'b0;
    load_len   = 1'b0;
    store_byte = 1'b0;
    frame_ok   = 1'b0;
    csum_bad   = 1'b0;
    len_bad    = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (i_RX_DV) begin
      case (state_q)
        IDLE: begin
          if (i_RX_Byte == SYNC_BYTE) begin
            sync_seen = 1'b1;
            state_d   = GET_CMD;
          end
        end
        GET_CMD: begin
          load_cmd = 1'b1;
          state_d  = GET_LEN;
        end
        GET_LEN: begin
          if (i_RX_Byte > 8'(MAX_LEN)) begin
            len_bad = 1'b1;
            state_d = IDLE;
          end else begin
            load_len = 1'b1;
            state_d  = (i_RX_Byte == 8'h00) ? GET_CSUM : GET_PAYLOAD;
          end
        end
        GET_PAYLOAD: begin
          // Sync-valued bytes are ordinary data here; no resynchronisation.
          store_byte = 1'b1;
          if (idx_q + 1'b1 == len_q) state_d = GET_CSUM;
        end
        GET_CSUM: begin
          frame_ok = (i_RX_Byte == sum_q);
          csum_bad = (i_RX_Byte != sum_q);
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      sum_q         <= '0;
      buf_q         <= '0;
      o_Cmd_Valid   <= 1'b0;
      o_Cmd         <= '0;
      o_Len         <= '0;
      o_Payload     <= '0;
      o_Err_Csum    <= 1'b0;
      o_Err_Len     <= 1'b0;
      o_Err_Timeout <= 1'b0;
      o_Frame_Cnt   <= '0;
    end else begin
      state_q       <= state_d;
      o_Cmd_Valid   <= frame_ok;
      o_Err_Csum    <= csum_bad;
      o_Err_Len     <= len_bad;
      o_Err_Timeout <= timeout;

      if (sync_seen) sum_q <= '0;
      if (load_cmd) begin
        cmd_q <= i_RX_Byte;
        sum_q <= i_RX_Byte;
      end
      if (load_len) begin
        len_q <= i_RX_Byte[IDX_W-1:0];
        idx_q <= '0;
        sum_q <= csum_add(sum_q, i_RX_Byte);
      end
      if (store_byte) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (idx_q == IDX_W'(i)) buf_q[i] <= i_RX_Byte;
        end
        idx_q <= idx_q + 1'b1;
        sum_q <= csum_add(sum_q, i_RX_Byte);
      end

      // Stale bytes from longer earlier frames are masked off at publish time.
      if (frame_ok) begin
        o_Cmd       <= cmd_q;
        o_Len       <= 4'(len_q);
        o_Frame_Cnt <= o_Frame_Cnt + 8'd1;
        for (int i = 0; i < MAX_LEN; i++) begin
          o_Payload[i*8 +: 8] <= (IDX_W'(i) < len_q) ? buf_q[i] : 8'h00;
        end
      end
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Consumes the byte stream from the UART receiver (one-cycle data-valid pulse plus byte) and assembles framed command packets for the robot controller. Frame format:
- SYNC byte
- CMD
- LEN
- LEN payload bytes
- 8-bit checksum

Only checksum-verified frames are presented downstream, as a held command/payload register set with a one-cycle valid strobe. Malformed or stalled frames are dropped and flagged by error pulses.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 8, maximum payload bytes accepted (1..15).
- TIMEOUT_CLKS, 7800, max clocks between bytes inside a frame (about 4 byte times at 195 clks/bit).

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_RX_DV  in  1  one-cycle byte-valid pulse from UART receiver.
- i_RX_Byte  in  8  received byte, valid when i_RX_DV=1.
- o_Cmd_Valid  out  1  one-cycle pulse, new verified frame on outputs.
- o_Cmd  out  8  command byte of last good frame.
- o_Len  out  4  payload length of last good frame.
- o_Payload  out  8*MAX_LEN  payload of last good frame; byte0 in [7:0]; unused bytes 0.
- o_Err_Csum  out  1  one-cycle pulse, checksum mismatch.
- o_Err_Len  out  1  one-cycle pulse, LEN > MAX_LEN.
- o_Err_Timeout  out  1  one-cycle pulse, inter-byte timeout.
- o_Frame_Cnt  out  8  count of good frames, wraps 255->0.

Behaviour:
- Reset (async, i_Rst_n=0):
  - All outputs 0, state IDLE, internal buffer, sum and timer 0.
  - Reset mid-frame discards the partial frame immediately.
- FSM states: IDLE, GET_CMD, GET_LEN, GET_PAYLOAD, GET_CSUM. All transitions occur only on cycles with i_RX_DV=1, except timeout.
- IDLE:
  - Byte == SYNC_BYTE -> GET_CMD, sum cleared.
  - Other bytes are ignored, with no error.
- GET_CMD: latch CMD into working register, sum = CMD -> GET_LEN.
- GET_LEN:
  - If LEN > MAX_LEN: pulse o_Err_Len -> IDLE.
  - Else latch LEN, sum += LEN, byte index = 0.
  - LEN == 0 -> GET_CSUM; else -> GET_PAYLOAD.
- GET_PAYLOAD:
  - Store byte at working buffer[index], sum += byte, index++.
  - index reaching LEN -> GET_CSUM.
  - SYNC_BYTE values are data here; there is no resync.
- GET_CSUM:
  - Byte == sum[7:0] (mod-256 sum of CMD, LEN, payload):
    - Next cycle: o_Cmd/o_Len/o_Payload loaded from working registers.
    - o_Payload bytes at index >= LEN are zeroed.
    - o_Cmd_Valid=1 for one cycle; o_Frame_Cnt++.
  - Mismatch: o_Err_Csum pulse, outputs unchanged.
  - Either case -> IDLE.
- Latency: o_Cmd_Valid rises exactly 1 clock after the i_RX_DV carrying the checksum byte. Error pulses have the same 1-clock latency after the offending byte.
- Output hold: o_Cmd/o_Len/o_Payload hold until the next good frame. Bad frames never modify them.
- Timeout:
  - Timer resets to 0 on every i_RX_DV and stays 0 in IDLE.
  - In any non-IDLE state it increments each clock without a byte.
  - Reaching TIMEOUT_CLKS-1: o_Err_Timeout pulse, -> IDLE, partial frame discarded.
  - If i_RX_DV arrives on the same cycle the timer would expire, the byte wins and no timeout occurs.
- The byte that caused an error is consumed and not re-examined as SYNC. The next frame needs a fresh SYNC.
- i_RX_DV held high for consecutive cycles is processed as one byte per cycle.
- Arithmetic:
  - Sum is 8-bit wraparound.
  - Index width is clog2(MAX_LEN+1).
  - Timer width is clog2(TIMEOUT_CLKS).
  - o_Frame_Cnt wraps silently.
- At most one of o_Cmd_Valid/o_Err_* is asserted in any cycle.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - FSM state enum.
  - SYNC_BYTE default.
  - Command code constants (e.g. CMD_MOTOR=8'h01, CMD_STOP=8'h02, CMD_PING=8'h03) used by downstream decoders.
- One natural sub-module, uart_byte_timeout: inter-byte watchdog counter with restart/enable inputs and expire pulse.
- Payload buffer and FSM stay in the top module.

Test Plan:
- Good frame: bytes A5 01 02 10 20 33 -> one cycle after the 33 byte:
  - o_Cmd_Valid=1, o_Cmd=01, o_Len=2.
  - o_Payload[15:0]=16'h2010, upper bytes 0.
  - o_Frame_Cnt=1.
- Zero-length frame: A5 03 00 03 -> o_Cmd_Valid, o_Cmd=03, o_Len=0, o_Payload all 0. Garbage bytes 55 FF before A5 are ignored with no errors.
- Bad checksum: A5 01 01 7F 00 -> o_Err_Csum pulse, no o_Cmd_Valid, previous outputs and o_Frame_Cnt unchanged. The following good frame A5 02 00 02 is accepted.
- Length error: A5 01 09 (MAX_LEN=8) -> o_Err_Len pulse one clock after 09; subsequent bytes ignored until A5.
- Timeout and boundary:
  - A5 01 then silence for TIMEOUT_CLKS clocks -> single o_Err_Timeout pulse, state IDLE.
  - Repeat with the next byte arriving exactly on the expiry cycle -> no timeout, frame completes normally.
- Reset and wrap:
  - Assert i_Rst_n=0 mid-payload -> all outputs 0 asynchronously. The frame restarted after release parses correctly.
  - 256 good frames -> o_Frame_Cnt wraps to 0.
